// File: rtl/i2s_pkg.sv
// Constants and state encoding shared by the I2S transmitter and receiver.
package i2s_pkg;

    localparam int unsigned I2S_SAMPLE_W   = 16;
    localparam int unsigned I2S_SLOT_BITS  = I2S_SAMPLE_W;
    localparam int unsigned I2S_FRAME_BITS = 2 * I2S_SLOT_BITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } i2s_state_t;

    function automatic int unsigned i2s_frame_bits(input int unsigned sample_w);
        return 2 * sample_w;
    endfunction

endpackage

// File: rtl/i2s_tx_clkgen.sv
// Bit-clock generator: mclk divider, registered bclk and single-cycle rise/fall strobes.
module i2s_clkgen
    import i2s_pkg::*;
#(
    parameter int unsigned MCLK_DIV = 4
) (
    input  logic mclk,
    input  logic rst,
    input  logic i_run,
    output logic o_bclk,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned DIV_W = (MCLK_DIV > 1) ? $clog2(MCLK_DIV) : 1;

    logic [DIV_W-1:0] r_div;
    logic             r_bclk;
    logic             w_tc;

    assign w_tc = i_run && (r_div == DIV_W'(MCLK_DIV - 1));

    // Outside RUN the divider is parked at zero so the first rise lands MCLK_DIV cycles into RUN.
    always_ff @(posedge mclk) begin
        if (rst || !i_run) begin
            r_div  <= '0;
            r_bclk <= 1'b0;
        end else if (w_tc) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
        end else begin
            r_div  <= r_div + 1'b1;
        end
    end

    assign o_bclk = r_bclk;
    assign o_rise = w_tc && !r_bclk;
    assign o_fall = w_tc && r_bclk;

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter / clock master with a one-frame holding buffer.
// Define I2S_TX_STEREO_EN for left-then-right transfers; otherwise each sample is duplicated to both slots.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int unsigned MCLK_DIV = 4,
    parameter int unsigned SAMPLE_W = I2S_SAMPLE_W
) (
    input  logic                mclk,
    input  logic                rst,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                sd,
    output logic                underrun
);

    localparam int unsigned FRAME_BITS = i2s_frame_bits(SAMPLE_W);
    localparam int unsigned IDX_W      = $clog2(FRAME_BITS);

    i2s_state_t r_state;
    i2s_state_t w_state_nxt;

    logic [SAMPLE_W-1:0]   r_buf_l;
    logic [SAMPLE_W-1:0]   r_buf_r;
    logic                  r_full;
    logic                  r_ready;
`ifdef I2S_TX_STEREO_EN
    logic                  r_half;
`endif
    logic [FRAME_BITS-1:0] r_shift;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_lrclk;
    logic                  r_underrun;

    logic w_bclk;
    logic w_rise;
    logic w_fall;
    logic w_run;
    logic w_load;
    logic w_frame_end;
    logic w_xfer;

    i2s_clkgen #(
        .MCLK_DIV (MCLK_DIV)
    ) u_clkgen (
        .mclk   (mclk),
        .rst    (rst),
        .i_run  (w_run),
        .o_bclk (w_bclk),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A frame wrap with en still high reloads in the falling-edge cycle instead of visiting LOAD.
    always_comb begin
        w_state_nxt = r_state;
        w_run       = 1'b0;
        w_load      = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_load      = 1'b1;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_run = 1'b1;
                if (w_fall && (r_idx == IDX_W'(FRAME_BITS - 1))) begin
                    w_frame_end = 1'b1;
                    if (en) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_xfer = s_valid && r_ready;

    always_ff @(posedge mclk) begin
        if (rst) begin
            r_buf_l    <= '0;
            r_buf_r    <= '0;
            r_full     <= 1'b0;
            r_ready    <= 1'b1;
`ifdef I2S_TX_STEREO_EN
            r_half     <= 1'b0;
`endif
            r_shift    <= '0;
            r_idx      <= '0;
            r_lrclk    <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;

            // A full buffer has s_ready low, so a load never coincides with an accepted transfer.
            if (w_load && r_full) begin
                r_full  <= 1'b0;
                r_ready <= 1'b1;
            end else if (w_xfer) begin
`ifdef I2S_TX_STEREO_EN
                if (!r_half) begin
                    r_buf_l <= s_data;
                    r_half  <= 1'b1;
                end else begin
                    r_buf_r <= s_data;
                    r_half  <= 1'b0;
                    r_full  <= 1'b1;
                    r_ready <= 1'b0;
                end
`else
                r_buf_l <= s_data;
                r_buf_r <= s_data;
                r_full  <= 1'b1;
                r_ready <= 1'b0;
`endif
            end

            if (w_load) begin
                r_idx   <= '0;
                r_lrclk <= 1'b0;
                if (r_full) begin
                    r_shift <= {r_buf_l, r_buf_r};
                end else begin
                    r_shift    <= '0;
                    r_underrun <= 1'b1;
                end
            end else if (w_frame_end) begin
                r_idx   <= '0;
                r_lrclk <= 1'b0;
                r_shift <= '0;
            end else if (w_fall) begin
                r_idx   <= r_idx + 1'b1;
                r_lrclk <= (r_idx >= IDX_W'(SAMPLE_W - 1));
                r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
            end
        end
    end

    assign s_ready  = r_ready;
    assign bclk     = w_bclk;
    assign lrclk    = r_lrclk;
    assign sd       = r_shift[FRAME_BITS-1];
    assign underrun = r_underrun;

endmodule

// File: tb/tb_i2s_tx.sv
// Scoreboard bench for i2s_tx: a pin-level receiver model decodes frames and checks them against queued expectations.
module tb_i2s_tx;

    localparam int DIV       = 4;
    localparam int SW        = 16;
    localparam int FRAME_CYC = 2 * SW * 2 * DIV;
    localparam int TMO       = 2000;
    localparam int NB        = 6;

    logic          mclk = 1'b0;
    logic          rst  = 1'b1;
    logic          en   = 1'b0;
    logic [SW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          bclk;
    logic          lrclk;
    logic          sd;
    logic          underrun;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int rise_cnt = 0;
    int frames_started = 0;
    int frames_done = 0;
    int ur_cnt = 0;
    int t_en = 0;
    bit bb_on = 1'b0;

    logic [2*SW-1:0] sbq[$];

    i2s_tx #(
        .MCLK_DIV (DIV),
        .SAMPLE_W (SW)
    ) dut (
        .mclk     (mclk),
        .rst      (rst),
        .en       (en),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sd       (sd),
        .underrun (underrun)
    );

    always #5 mclk = ~mclk;

    always @(posedge mclk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [SW-1:0] rnd();
        return SW'($urandom);
    endfunction

    // Receiver model: sample sd on every bclk rise, slot by rise count, compare whole frames.
    initial begin : monitor
        logic          pb;
        logic          pl;
        logic          pr;
        logic [SW-1:0] accl;
        logic [SW-1:0] accr;
        logic [2*SW-1:0] e;
        int            last_lr;
        pb = 1'b0; pl = 1'b0; pr = 1'b1;
        accl = '0; accr = '0; last_lr = -1;
        forever begin
            @(negedge mclk);
            if (rst) begin
                rise_cnt = 0;
            end else begin
                if (underrun === 1'b1) ur_cnt++;
                if (bclk === 1'b1 && !pb) begin
                    if (rise_cnt == 0) frames_started++;
                    chk("lrclk_slot", 32'(lrclk), (rise_cnt >= SW) ? 32'd1 : 32'd0);
                    if (rise_cnt < SW) accl = {accl[SW-2:0], sd};
                    else               accr = {accr[SW-2:0], sd};
                    rise_cnt++;
                    if (rise_cnt == 2 * SW) begin
                        rise_cnt = 0;
                        frames_done++;
                        if (sbq.size() == 0) begin
                            chk("frame_expected", 32'(sbq.size()), 32'd1);
                        end else begin
                            e = sbq.pop_front();
                            chk("frame_left", 32'(accl), 32'(e[2*SW-1:SW]));
                            chk("frame_right", 32'(accr), 32'(e[SW-1:0]));
                        end
                    end
                end
                if (bb_on) begin
                    if (lrclk === 1'b1 && !pl) begin
                        if (last_lr >= 0) chk("lrclk_period", 32'(cyc - last_lr), 32'(FRAME_CYC));
                        last_lr = cyc;
                    end
                    if (s_ready === 1'b1 && !pr)
                        chk("ready_after_load", 32'((cyc - t_en - 2) % FRAME_CYC), 32'd0);
                end else begin
                    last_lr = -1;
                end
            end
            pb = bclk; pl = lrclk; pr = s_ready;
        end
    end

    task automatic push_word(input logic [SW-1:0] d);
        int t = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (s_ready !== 1'b1 && t < TMO) begin
            @(negedge mclk);
            t++;
        end
        chk("push_accepted", 32'(s_ready), 32'd1);
        @(negedge mclk);
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
`ifdef I2S_TX_STEREO_EN
        sbq.push_back({l, r});
        push_word(l);
        push_word(r);
`else
        sbq.push_back({l, l});
        push_word(l);
`endif
    endtask

    task automatic wait_started(input int n);
        int t = 0;
        while (frames_started < n && t < TMO) begin
            @(negedge mclk);
            t++;
        end
        chk("frame_started_in_time", 32'(frames_started >= n), 32'd1);
    endtask

    task automatic wait_done(input int n);
        int t = 0;
        while (frames_done < n && t < TMO) begin
            @(negedge mclk);
            t++;
        end
        chk("frame_done_in_time", 32'(frames_done >= n), 32'd1);
    endtask

    task automatic wait_rise(input int v);
        int t = 0;
        while (rise_cnt < v && t < TMO) begin
            @(negedge mclk);
            t++;
        end
        chk("bit_reached_in_time", 32'(rise_cnt >= v), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        repeat (2) @(negedge mclk);
        sbq.delete();
        rst = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_bclk"}, 32'(bclk), 32'd0);
        chk({tag, "_lrclk"}, 32'(lrclk), 32'd0);
        chk({tag, "_sd"}, 32'(sd), 32'd0);
        chk({tag, "_underrun"}, 32'(underrun), 32'd0);
        chk({tag, "_s_ready"}, 32'(s_ready), 32'd1);
    endtask

    initial begin : stim
        logic [SW-1:0] a;
        logic [SW-1:0] b;
        int s0;
        int d0;
        int u0;
        int n;

        rst = 1'b1;
        repeat (3) @(negedge mclk);
        chk_idle_outputs("reset");
        rst = 1'b0;
        @(negedge mclk);

        // Known pattern, then an underrun frame, then a sample supplied mid-frame, then en dropped.
        s0 = frames_started; d0 = frames_done; u0 = ur_cnt;
`ifdef I2S_TX_STEREO_EN
        a = 16'h8001; b = 16'h7FFE;
`else
        a = 16'hA5C3; b = 16'hA5C3;
`endif
        send_frame(a, b);
        en = 1'b1;
        sbq.push_back('0);
        n = 0;
        do begin
            @(negedge mclk);
            n++;
        end while (bclk !== 1'b1 && n < 100);
        // one cycle for en to be registered into LOAD, then LOAD + MCLK_DIV
        chk("first_bclk_rise", 32'(n), 32'(2 + DIV));
        wait_started(s0 + 2);
        wait_rise(5);
        send_frame(16'h1234, 16'h1234);
        wait_started(s0 + 3);
        en = 1'b0;
        wait_done(d0 + 3);
        repeat (4) @(negedge mclk);
        chk_idle_outputs("idle_after_en0");
        repeat (100) @(negedge mclk);
        chk("idle_no_new_frames", 32'(frames_started - s0), 32'd3);
        chk("underrun_pulses_a", 32'(ur_cnt - u0), 32'd1);

        // Back-to-back random frames with a short en drop inside one frame.
        do_reset();
        s0 = frames_started; d0 = frames_done; u0 = ur_cnt;
        send_frame(rnd(), rnd());
        en = 1'b1;
        t_en = cyc;
        bb_on = 1'b1;
        fork
            begin
                for (int i = 1; i < NB; i++) send_frame(rnd(), rnd());
            end
            begin
                wait_started(s0 + 3);
                wait_rise(10);
                en = 1'b0;
                repeat (20) @(negedge mclk);
                en = 1'b1;
            end
        join
        wait_started(s0 + NB);
        en = 1'b0;
        wait_done(d0 + NB);
        bb_on = 1'b0;
        chk("underrun_pulses_b", 32'(ur_cnt - u0), 32'd0);

        // Reset at bit 7 with a further frame buffered; both must be discarded.
        do_reset();
        s0 = frames_started; u0 = ur_cnt;
        send_frame(rnd(), rnd());
        en = 1'b1;
        wait_started(s0 + 1);
        wait_rise(3);
        send_frame(rnd(), rnd());
        wait_rise(7);
        rst = 1'b1;
        en  = 1'b0;
        @(negedge mclk);
        chk_idle_outputs("reset_mid_frame");
        @(negedge mclk);
        sbq.delete();
        rst = 1'b0;
        s0 = frames_started; d0 = frames_done;
        send_frame(rnd(), rnd());
        en = 1'b1;
        wait_started(s0 + 1);
        en = 1'b0;
        wait_done(d0 + 1);
        chk("underrun_pulses_c", 32'(ur_cnt - u0), 32'd0);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin : watchdog
        repeat (40000) @(posedge mclk);
        $display("FAIL watchdog: run did not complete, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
